// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared widths, funct3 codes, FSM states and access-size helpers
package data_mem_responder_pkg;

  localparam int DataWidth  = 32;
  localparam int AddrWidth  = 32;
  localparam int Func3Width = 3;

  localparam logic [Func3Width-1:0] F3_B  = 3'b000;
  localparam logic [Func3Width-1:0] F3_H  = 3'b001;
  localparam logic [Func3Width-1:0] F3_W  = 3'b010;
  localparam logic [Func3Width-1:0] F3_BU = 3'b100;
  localparam logic [Func3Width-1:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unsigned encodings only exist for loads; any unlisted code is a full word.
  function automatic size_e access_size(input logic is_write, input logic [Func3Width-1:0] func3);
    size_e sz;
    sz = SZ_W;
    if (func3 == F3_B || (!is_write && func3 == F3_BU)) begin
      sz = SZ_B;
    end else if (func3 == F3_H || (!is_write && func3 == F3_HU)) begin
      sz = SZ_H;
    end else if (func3 == F3_W) begin
      sz = SZ_W;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    logic mis;
    case (sz)
      SZ_H:    mis = lo[0];
      SZ_W:    mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte offset inside the word after dropping the low bits the size cannot use.
  function automatic logic [1:0] align_offset(input size_e sz, input logic [1:0] lo);
    logic [1:0] off;
    case (sz)
      SZ_B:    off = lo;
      SZ_H:    off = {lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between the memory stage and the responder
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [AddrWidth-1:0]  reqAddr;
  logic [Func3Width-1:0] reqFunc3;
  logic [DataWidth-1:0]  reqWriteData;
  logic                  respValid;
  logic [DataWidth-1:0]  respReadData;
  logic                  respError;

  modport master (
    output reqValid, reqWrite, reqAddr, reqFunc3, reqWriteData,
    input  reqReady, respValid, respReadData, respError
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqFunc3, reqWriteData,
    output reqReady, respValid, respReadData, respError
  );

endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// rtl/data_mem_responder_mem_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [DataWidth-1:0] rd_word,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [1:0]           offset,
  input  size_e                size,
  input  logic                 is_unsigned,
  output logic [DataWidth-1:0] ld_data,
  output logic [DataWidth-1:0] st_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed lane and sign- or zero-extend it for loads.
  always_comb begin
    sel_byte = rd_word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data  = rd_word;
    case (size)
      SZ_B:    ld_data = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
      SZ_H:    ld_data = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
      default: ld_data = rd_word;
    endcase
  end

  // Replace only the addressed lanes of the old word for stores.
  always_comb begin
    st_word = rd_word;
    case (size)
      SZ_B:    st_word[{offset, 3'b000} +: 8] = wr_data[7:0];
      SZ_H:    st_word[{offset[1], 4'b0000} +: 16] = wr_data[15:0];
      default: st_word = wr_data;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshake data-memory responder; MISALIGN_TRAP_EN turns misaligned accesses into error responses
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

`ifdef MISALIGN_TRAP_EN
  localparam logic TrapEn = 1'b1;
`else
  localparam logic TrapEn = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [1:0]           off_q, off_d;
  size_e                size_q, size_d;
  logic                 uns_q, uns_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rd_word_q, rd_word_d;
  logic [DataWidth-1:0] resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;

  logic [DataWidth-1:0] mem_q [DEPTH_WORDS];
  logic                 mem_we;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] lane_rd_word;
  logic [DataWidth-1:0] ld_data;
  logic [DataWidth-1:0] st_word;
  size_e                req_size;
  logic                 unused_addr_bits;

  // Address bits above the word index only alias onto the array.
  assign unused_addr_bits = ^bus.reqAddr[AddrWidth-1:AW+2];
  assign req_size         = access_size(bus.reqWrite, bus.reqFunc3);
  assign lane_rd_word     = (state_q == ST_RD) ? mem_q[idx_q] : rd_word_q;

  mem_lane_align u_lane (
    .rd_word     (lane_rd_word),
    .wr_data     (wdata_q),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  assign bus.reqReady     = (state_q == ST_IDLE) && !reset;
  assign bus.respValid    = (state_q == ST_RESP);
  assign bus.respReadData = resp_data_q;
  assign bus.respError    = TrapEn & resp_err_q;

  // Next state, request capture and array write; response registers move only on entry to RESP.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rd_word_d   = rd_word_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_we      = 1'b0;
    mem_wdata   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.reqValid) begin
          idx_d   = bus.reqAddr[AW+1:2];
          off_d   = align_offset(req_size, bus.reqAddr[1:0]);
          size_d  = req_size;
          uns_d   = bus.reqFunc3[2];
          write_d = bus.reqWrite;
          wdata_d = bus.reqWriteData;
          if (TrapEn && is_misaligned(req_size, bus.reqAddr[1:0])) begin
            state_d     = ST_RESP;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end else if (bus.reqWrite && req_size == SZ_W) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        rd_word_d = mem_q[idx_q];
        if (write_q) begin
          state_d = ST_MERGE;
        end else begin
          state_d     = ST_RESP;
          resp_data_d = ld_data;
          resp_err_d  = 1'b0;
        end
      end
      ST_MERGE: begin
        mem_we      = !reset;
        mem_wdata   = st_word;
        state_d     = ST_RESP;
        resp_data_d = '0;
        resp_err_d  = 1'b0;
      end
      ST_WR: begin
        mem_we      = !reset;
        mem_wdata   = wdata_q;
        state_d     = ST_RESP;
        resp_data_d = '0;
        resp_err_d  = 1'b0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      off_q       <= 2'b00;
      size_q      <= SZ_W;
      uns_q       <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rd_word_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rd_word_q   <= rd_word_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Storage array: contents survive reset, writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed checks of data_mem_responder against a byte-level memory model
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH = 1024;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          check_en = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned acc;
    int unsigned due;
    bit          lit_en;
    logic [31:0] lit;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [DEPTH];

  data_mem_responder_if bus_if();

  data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input bit wr, input logic [2:0] f3);
    if (f3 == F3_B || (!wr && f3 == F3_BU)) return 1;
    if (f3 == F3_H || (!wr && f3 == F3_HU)) return 2;
    return 4;
  endfunction

  task automatic junk(input bit hold);
    bus_if.reqValid     = hold;
    bus_if.reqWrite     = 1'($urandom);
    bus_if.reqAddr      = $urandom;
    bus_if.reqFunc3     = 3'($urandom);
    bus_if.reqWriteData = $urandom;
  endtask

  // Called at a negedge; presents the request once the responder is ready and records what it must answer.
  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input bit lit_en, input logic [31:0] lit, input bit hold, input bit abandon);
    int w;
    int n;
    int off;
    int widx;
    int lat;
    exp_t e;
    logic [63:0] mask;
    logic [63:0] v;
    w = 0;
    while (!bus_if.reqReady && w < 40) begin
      junk(hold);
      @(negedge clk);
      w++;
    end
    if (!bus_if.reqReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: reqReady=0 after %0d cycles, required 1", w);
      return;
    end
    bus_if.reqValid     = 1'b1;
    bus_if.reqWrite     = wr;
    bus_if.reqAddr      = addr;
    bus_if.reqFunc3     = f3;
    bus_if.reqWriteData = wd;
    n    = nbytes(wr, f3);
    off  = int'(addr % 4) - int'(addr % 4) % n;
    widx = int'((addr / 4) % DEPTH);
    e.acc    = cyc + 1;
    e.lit_en = lit_en;
    e.lit    = lit;
    e.err    = 1'b0;
    e.data   = 32'd0;
    mask     = ((64'd1 << (8 * n)) - 64'd1) << (8 * off);
    if (TRAP && (addr % n) != 0) begin
      e.err = 1'b1;
      lat   = 0;
    end else if (!wr) begin
      v = ({32'd0, mm[widx]} & mask) >> (8 * off);
      if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      e.data = v[31:0];
      lat    = 1;
    end else begin
      v = ({32'd0, mm[widx]} & ~mask) | (({32'd0, wd} << (8 * off)) & mask);
      if (!abandon) mm[widx] = v[31:0];
      lat = (n == 4) ? 1 : 2;
    end
    e.due = e.acc + lat;
    if (!abandon) q.push_back(e);
    @(negedge clk);
    junk(hold);
  endtask

  // Single compare process: response timing, data, error and busy-ready every cycle out of reset.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      automatic bit ev = (q.size() > 0) && (cyc == q[0].due);
      chk1("resp_valid", bus_if.respValid, ev);
      if (bus_if.respValid && ev) begin
        chk32("resp_data", bus_if.respReadData, q[0].data);
        chk1("resp_error", bus_if.respError, q[0].err);
        if (q[0].lit_en) chk32("resp_literal", bus_if.respReadData, q[0].lit);
      end
      if (q.size() > 0 && cyc >= q[0].acc) chk1("ready_busy", bus_if.reqReady, 1'b0);
      if (q.size() > 0 && cyc >= q[0].due) void'(q.pop_front());
    end
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [2:0]  f;
    bit          w;
    bit          h;
    bus_if.reqValid     = 1'b0;
    bus_if.reqWrite     = 1'b0;
    bus_if.reqAddr      = 32'd0;
    bus_if.reqFunc3     = 3'd0;
    bus_if.reqWriteData = 32'd0;

    repeat (2) @(negedge clk);
    chk1("reset_ready", bus_if.reqReady, 1'b0);
    chk1("reset_resp_valid", bus_if.respValid, 1'b0);
    chk32("reset_resp_data", bus_if.respReadData, 32'd0);
    chk1("reset_resp_error", bus_if.respError, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk1("ready_after_reset", bus_if.reqReady, 1'b1);
    check_en = 1'b1;

    for (int i = 0; i < 32; i++) do_req(1'b1, F3_W, 32'(i * 4), $urandom, 1'b0, 32'd0, 1'b0, 1'b0);

    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, F3_W, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);

    do_req(1'b1, F3_W,  32'h20, 32'h80FF7F01, 1'b0, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, F3_B,  32'h23, 32'd0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    do_req(1'b0, F3_BU, 32'h23, 32'd0, 1'b1, 32'h00000080, 1'b0, 1'b0);
    do_req(1'b0, F3_H,  32'h22, 32'd0, 1'b1, 32'hFFFF80FF, 1'b0, 1'b0);
    do_req(1'b0, F3_HU, 32'h20, 32'd0, 1'b1, 32'h00007F01, 1'b0, 1'b0);

    do_req(1'b1, F3_W, 32'h30, 32'h11223344, 1'b0, 32'd0, 1'b0, 1'b0);
    do_req(1'b1, F3_B, 32'h31, 32'h000000AA, 1'b1, 32'd0, 1'b0, 1'b0);
    do_req(1'b1, F3_H, 32'h32, 32'h0000BEEF, 1'b1, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, F3_W, 32'h30, 32'd0, 1'b1, 32'hBEEFAA44, 1'b0, 1'b0);

    do_req(1'b1, F3_W, 32'h40, 32'h01234567, 1'b0, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, F3_W, 32'h41, 32'd0, 1'b1, TRAP ? 32'd0 : 32'h01234567, 1'b0, 1'b0);
    do_req(1'b1, F3_W, 32'h42, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, F3_W, 32'h40, 32'd0, 1'b1, TRAP ? 32'h01234567 : 32'hFFFFFFFF, 1'b0, 1'b0);

    do_req(1'b1, F3_W, 32'h50, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    do_req(1'b1, F3_B, 32'h50, 32'h00000055, 1'b0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk1("ready_in_reset", bus_if.reqReady, 1'b0);
    chk1("no_resp_in_reset", bus_if.respValid, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    do_req(1'b0, F3_W, 32'h50, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);

    do_req(1'b1, F3_W, 32'h0, 32'hCAFEF00D, 1'b0, 32'd0, 1'b0, 1'b0);
    do_req(1'b0, F3_W, 32'(DEPTH * 4), 32'd0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      a = {r[31:12], 5'd0, 5'($urandom_range(0, 31)), r[1:0]};
      f = 3'($urandom);
      w = 1'($urandom);
      h = (k != 299) && ($urandom_range(0, 1) == 1);
      do_req(w, f, a, $urandom, 1'b0, 32'd0, h, 1'b0);
    end
    bus_if.reqValid = 1'b0;

    repeat (6) @(negedge clk);
    chk32("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
